branch_cmp_pipe: RTL and testbench

Parametrised, two-stage pipelined branch comparator for the pipelined CPU datapath and its branch-resolution path. Supports six relations (EQ, NE, LT, LE, GT, GE) in signed or unsigned form on WIDTH-bit operands. Uses valid/ready handshaking with backpressure and a flush input, carries a tag alongside each result, and keeps saturating taken/total statistics counters.

---
 rtl/branch_cmp_pipe_pkg.sv | 33 +++
 rtl/cmp_core.sv | 19 +
 rtl/branch_cmp_pipe.sv | 103 ++++++++++
 tb/tb_branch_cmp_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_cmp_pipe_pkg.sv
// rtl/branch_cmp_pipe_pkg.sv - shared compare-mode encodings and result resolution
package branch_cmp_pipe_pkg;

  localparam int CMP_MODE_W = 3;

  typedef enum logic [CMP_MODE_W-1:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_LT = 3'd2,
    CMP_LE = 3'd3,
    CMP_GT = 3'd4,
    CMP_GE = 3'd5
  } cmp_mode_e;

  // Reduce the two primitive flags to the requested relation; codes 6/7 are never true.
  function automatic logic cmp_resolve(input logic [CMP_MODE_W-1:0] mode,
                                       input logic eq,
                                       input logic lt);
    logic r;
    r = 1'b0;
    case (mode)
      CMP_EQ:  r = eq;
      CMP_NE:  r = !eq;
      CMP_LT:  r = lt;
      CMP_LE:  r = lt | eq;
      CMP_GT:  r = !lt & !eq;
      CMP_GE:  r = !lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_core.sv
// rtl/cmp_core.sv - combinational equality and less-than flags, signed or unsigned
module cmp_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             uns,
  output logic             eq,
  output logic             lt
);

  // Direct magnitude compare; avoids deriving lt from the sign of a-b.
  always_comb begin
    eq = (a == b);
    if (uns) lt = (a < b);
    else     lt = ($signed(a) < $signed(b));
  end

endmodule

// File: rtl/branch_cmp_pipe.sv
// rtl/branch_cmp_pipe.sv - two-stage branch comparator with handshake, flush and statistics
module branch_cmp_pipe
  import branch_cmp_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  input  logic [CMP_MODE_W-1:0] mode,
  input  logic                  uns,
  input  logic [TAG_W-1:0]      tag_in,
  input  logic                  flush,
  input  logic                  clr_cnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  res,
  output logic [TAG_W-1:0]      tag_out,
  output logic [CNT_W-1:0]      taken_cnt,
  output logic [CNT_W-1:0]      total_cnt
);

  logic                  cmp_eq, cmp_lt;
  logic                  s1_valid, s1_eq, s1_lt;
  logic [CMP_MODE_W-1:0] s1_mode;
  logic [TAG_W-1:0]      s1_tag;
  logic                  s2_valid;
  logic                  s2_adv, s1_adv, accept, out_hs;

  cmp_core #(.WIDTH(WIDTH)) u_cmp_core (
    .a   (src_a),
    .b   (src_b),
    .uns (uns),
    .eq  (cmp_eq),
    .lt  (cmp_lt)
  );

  // Stage advance chain; out_ready feeds in_ready combinationally so a full pipe restarts at once.
  always_comb begin
    s2_adv   = !s2_valid | out_ready;
    s1_adv   = !s1_valid | s2_adv;
    in_ready = s1_adv;
    accept   = in_valid & s1_adv;
    out_hs   = s2_valid & out_ready;
  end

  assign out_valid = s2_valid;

  // Stage 1: capture compare flags, mode and tag of an accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_eq    <= 1'b0;
      s1_lt    <= 1'b0;
      s1_mode  <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_eq   <= cmp_eq;
        s1_lt   <= cmp_lt;
        s1_mode <= mode;
        s1_tag  <= tag_in;
      end
    end
  end

  // Stage 2: resolve the relation; result and tag only move when the stage advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      res      <= 1'b0;
      tag_out  <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        res     <= cmp_resolve(s1_mode, s1_eq, s1_lt);
        tag_out <= s1_tag;
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle handshake, flush does not suppress counting.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      taken_cnt <= '0;
      total_cnt <= '0;
    end else if (out_hs) begin
      if (total_cnt != {CNT_W{1'b1}}) total_cnt <= total_cnt + 1'b1;
      if (res && (taken_cnt != {CNT_W{1'b1}})) taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// tb/tb_branch_cmp_pipe.sv - randomized and directed self-checking bench for branch_cmp_pipe
module tb_branch_cmp_pipe;
  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset, in_valid, uns, flush, clr_cnt, out_ready;
  logic [W-1:0]  src_a, src_b;
  logic [2:0]    mode;
  logic [TW-1:0] tag_in;

  logic          in_ready, out_valid, res;
  logic [TW-1:0] tag_out;
  logic [15:0]   taken_cnt, total_cnt;
  logic          in_ready_s, out_valid_s, res_s;
  logic [TW-1:0] tag_out_s;
  logic [1:0]    taken_cnt_s, total_cnt_s;

  always #5 clk = ~clk;

  branch_cmp_pipe #(.WIDTH(W), .TAG_W(TW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .mode(mode), .uns(uns), .tag_in(tag_in),
    .flush(flush), .clr_cnt(clr_cnt), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .tag_out(tag_out), .taken_cnt(taken_cnt), .total_cnt(total_cnt)
  );

  branch_cmp_pipe #(.WIDTH(W), .TAG_W(TW), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .src_a(src_a), .src_b(src_b), .mode(mode), .uns(uns), .tag_in(tag_in),
    .flush(flush), .clr_cnt(clr_cnt), .out_valid(out_valid_s), .out_ready(out_ready),
    .res(res_s), .tag_out(tag_out_s), .taken_cnt(taken_cnt_s), .total_cnt(total_cnt_s)
  );

  typedef struct {
    bit            r;
    logic [TW-1:0] tag;
    int            vis;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t16 = 0, k16 = 0, t2 = 0, k2 = 0;

  function automatic bit ref_rel(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] m, input bit u);
    longint sa, sb;
    sa = u ? longint'(a) : longint'($signed(a));
    sb = u ? longint'(b) : longint'($signed(b));
    case (m)
      3'd0:    return sa == sb;
      3'd1:    return sa != sb;
      3'd2:    return sa <  sb;
      3'd3:    return sa <= sb;
      3'd4:    return sa >  sb;
      3'd5:    return sa >= sb;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m,
                     input logic u, input logic [TW-1:0] t);
    in_valid = 1'b1;
    src_a = a; src_b = b; mode = m; uns = u; tag_in = t;
  endtask

  task automatic step();
    bit   exp_ir, exp_ov, hs, acc;
    ent_t e;
    exp_ir = 1'b0; exp_ov = 1'b0;
    #1;
    if (!reset) begin
      exp_ir = (q.size() < 2) || out_ready;
      exp_ov = (q.size() > 0) && (q[0].vis <= cyc);
      chk("in_ready", in_ready, exp_ir);
      chk("in_ready_sat", in_ready_s, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      chk("out_valid_sat", out_valid_s, exp_ov);
      if (exp_ov) begin
        chk("res", res, q[0].r);
        chk("tag_out", tag_out, q[0].tag);
        chk("res_sat", res_s, q[0].r);
      end
    end
    hs  = !reset && exp_ov && out_ready;
    acc = !reset && in_valid && exp_ir;
    @(posedge clk);
    cyc++;
    if (reset) begin
      q.delete();
      t16 = 0; k16 = 0; t2 = 0; k2 = 0;
    end else begin
      if (hs) begin
        e = q.pop_front();
        if (!clr_cnt) begin
          if (t16 < 65535) t16++;
          if (t2 < 3) t2++;
          if (e.r && k16 < 65535) k16++;
          if (e.r && k2 < 3) k2++;
        end
      end
      if (clr_cnt) begin
        t16 = 0; k16 = 0; t2 = 0; k2 = 0;
      end
      if (flush) q.delete();
      else if (acc) q.push_back('{ref_rel(src_a, src_b, mode, uns), tag_in, cyc + 1});
    end
    #1;
    chk("total_cnt", total_cnt, t16);
    chk("taken_cnt", taken_cnt, k16);
    chk("total_cnt_sat", total_cnt_s, t2);
    chk("taken_cnt_sat", taken_cnt_s, k2);
  endtask

  function automatic logic [W-1:0] pick_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return {1'b0, {(W-1){1'b1}}};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; uns = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    out_ready = 1'b1; src_a = '0; src_b = '0; mode = '0; tag_in = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_tag_out", tag_out, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_total", total_cnt, 0);
    chk("rst_taken", taken_cnt, 0);

    req(5, 5, 3'd0, 1'b0, 5'd1); step();
    in_valid = 1'b0; repeat (3) step();
    chk("eq55_total", total_cnt, 1);
    chk("eq55_taken", taken_cnt, 1);

    req(32'hFFFF_FFFF, 1, 3'd2, 1'b0, 5'd2); step();
    req(32'hFFFF_FFFF, 1, 3'd2, 1'b1, 5'd3); step();
    req(32'h8000_0000, 32'h7FFF_FFFF, 3'd4, 1'b0, 5'd4); step();
    in_valid = 1'b0; repeat (3) step();

    for (int i = 0; i < 6; i++) begin
      req(3, 7, 3'(i), 1'b0, 5'(i)); step();
    end
    in_valid = 1'b0; repeat (3) step();

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(pick_op(), pick_op(), 3'($urandom_range(0, 5)), 1'($urandom), 5'(10 + i)); step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req(pick_op(), pick_op(), 3'($urandom_range(0, 5)), 1'($urandom), 5'(14 + i)); step();
    end
    in_valid = 1'b0; repeat (4) step();

    out_ready = 1'b0;
    req(1, 2, 3'd2, 1'b0, 5'd20); step();
    req(2, 2, 3'd0, 1'b0, 5'd21); step();
    req(3, 2, 3'd4, 1'b0, 5'd22); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; step();
    out_ready = 1'b1;
    req(9, 9, 3'd0, 1'b0, 5'd23); step();
    in_valid = 1'b0; repeat (3) step();

    for (int i = 0; i < 5; i++) begin
      req(1, 1, 3'd0, 1'b0, 5'(24 + i)); step();
    end
    in_valid = 1'b0; repeat (2) step();
    chk("sat_total", total_cnt_s, 3);
    chk("sat_taken", taken_cnt_s, 3);
    req(2, 2, 3'd0, 1'b0, 5'd30); step();
    in_valid = 1'b0; step();
    clr_cnt = 1'b1; step();
    clr_cnt = 1'b0; step();
    chk("clr_total", total_cnt, 0);
    chk("clr_taken", taken_cnt, 0);

    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a;
      a = pick_op();
      in_valid  = ($urandom_range(0, 3) != 0);
      src_a     = a;
      src_b     = ($urandom_range(0, 3) == 0) ? a : pick_op();
      mode      = 3'($urandom_range(0, 7));
      uns       = 1'($urandom);
      tag_in    = 5'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      clr_cnt   = ($urandom_range(0, 29) == 0);
      reset     = (i == 200);
      step();
    end
    reset = 1'b0; flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
